// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-side constants and the register-dump FSM state encoding.
//   REG_NUM     : number of architectural registers
//   REG_ADDR_W  : register index width
//   DATA_W      : register data width
//   dump_state_e: IDLE / READ / SEND / DONE for reg_dump_reader
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader_if.sv
// ---------------------------------------------------------------------------
// reg_dump_reader_if
// Bundles the control, register-file read port and stream signals of the
// register dump reader.
//   master : the dump reader itself (drives address, stream and status)
//   slave  : the board side (drives start/abort, read data and ready)
// Signals:
//   start_i/abort_i     dump request / abort
//   rR_o/rD_i           register-file read port 2 address / data
//   dout_o/idx_o        stream word value / register index
//   valid_o/ready_i     stream handshake
//   busy_o/done_o       status
// ---------------------------------------------------------------------------
interface reg_dump_reader_if;
  import cpu_pkg::*;

  logic                  start_i;
  logic                  abort_i;
  logic [REG_ADDR_W-1:0] rR_o;
  logic [DATA_W-1:0]     rD_i;
  logic [DATA_W-1:0]     dout_o;
  logic [REG_ADDR_W-1:0] idx_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    input  start_i, abort_i, rD_i, ready_i,
    output rR_o, dout_o, idx_o, valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, abort_i, rD_i, ready_i,
    input  rR_o, dout_o, idx_o, valid_o, busy_o, done_o
  );

endinterface

// File: rtl/reg_dump_reader.sv
// ---------------------------------------------------------------------------
// reg_dump_reader
// Walks registers FIRST_REG..LAST_REG through register-file read port 2 and
// streams each (index, value) pair over a valid/ready handshake.
// Ports:
//   clk_i      system clock, rising edge
//   reset_n_i  asynchronous active-low reset
//   bus        reg_dump_reader_if.master (control, read port, stream, status)
// Parameters:
//   FIRST_REG  first register index dumped
//   LAST_REG   last register index dumped (FIRST_REG..REG_NUM-1)
// ---------------------------------------------------------------------------
module reg_dump_reader
  import cpu_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  reg_dump_reader_if.master    bus
);

  // Reject an empty or out-of-range dump window at elaboration.
  if ((FIRST_REG > LAST_REG) || (LAST_REG >= REG_NUM)) begin : g_bad_range
    $error("reg_dump_reader: illegal range FIRST_REG=%0d LAST_REG=%0d",
           FIRST_REG, LAST_REG);
  end

  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

  dump_state_e           state_r;
  logic [REG_ADDR_W-1:0] cnt_r;
  logic [DATA_W-1:0]     dout_r;
  logic [REG_ADDR_W-1:0] idx_r;
  logic                  valid_r;
  logic                  done_r;
  logic                  accept_s;

  // Stream word is consumed on a valid/ready handshake.
  assign accept_s = valid_r & bus.ready_i;

  // The counter doubles as the read address; it is cleared whenever the FSM
  // returns to IDLE so the port sees address 0 while the reader is idle.
  assign bus.rR_o    = cnt_r;
  assign bus.dout_o  = dout_r;
  assign bus.idx_o   = idx_r;
  assign bus.valid_o = valid_r;
  assign bus.done_o  = done_r;
  assign bus.busy_o  = (state_r != IDLE);

  // Dump FSM with index counter and stream output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      dout_r  <= '0;
      idx_r   <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if ((state_r != IDLE) && bus.abort_i) begin
        // Abort wins over any transition; a pending word is dropped.
        state_r <= IDLE;
        cnt_r   <= '0;
        valid_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            // Abort alongside start keeps the reader idle.
            if (bus.start_i && !bus.abort_i) begin
              cnt_r   <= FIRST_IDX;
              state_r <= READ;
            end else begin
              state_r <= IDLE;
            end
          end
          READ: begin
            dout_r  <= bus.rD_i;
            idx_r   <= cnt_r;
            valid_r <= 1'b1;
            state_r <= SEND;
          end
          SEND: begin
            if (accept_s) begin
              valid_r <= 1'b0;
              // Compare before incrementing so LAST_IDX=31 never wraps.
              if (cnt_r == LAST_IDX) begin
                done_r  <= 1'b1;
                state_r <= DONE;
              end else begin
                cnt_r   <= cnt_r + 5'd1;
                state_r <= READ;
              end
            end else begin
              state_r <= SEND;
            end
          end
          DONE: begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end
          default: begin
            cnt_r   <= '0;
            valid_r <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_reader
// Self-checking bench for reg_dump_reader: a full-range instance (0..31) and
// a single-register instance (10..10) share a behavioural register file.
// ---------------------------------------------------------------------------
module tb_reg_dump_reader;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reg_dump_reader_if bus1();
  reg_dump_reader_if bus2();

  logic [31:0] rf [REG_NUM];

  assign bus1.rD_i = rf[bus1.rR_o];
  assign bus2.rD_i = rf[bus2.rR_o];

  reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus1.master)
  );

  reg_dump_reader #(.FIRST_REG(10), .LAST_REG(10)) dut_one (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus2.master)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h1111_1111;
  endtask

  task automatic fill_random();
    rf[0] = 32'h0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
  endtask

  // Runs one dump on the full-range instance against a queue-free scoreboard:
  // words must arrive in order 0..31 with the register-file value, a stalled
  // word must stay frozen, and exactly one done pulse must follow word 31.
  task automatic dump(input int ready_pct, input int stall_idx, input int stall_len,
                      input int restart_idx, input int abort_idx, output int words);
    int exp_idx = 0;
    int dones = 0;
    int stall = stall_len;
    int cyc = 0;
    bit prev_hold = 1'b0;
    bit finished = 1'b0;
    bit restarted = 1'b0;
    logic [31:0] h_dout = 32'h0;
    logic [4:0] h_idx = 5'd0;
    bus1.ready_i = 1'b1;
    bus1.start_i = 1'b1;
    step();
    while (!finished && cyc < 2000) begin
      cyc++;
      bus1.start_i = 1'b0;
      if (prev_hold) begin
        chk("hold_valid", bus1.valid_o, 1);
        chk("hold_idx", bus1.idx_o, h_idx);
        chk("hold_dout", bus1.dout_o, h_dout);
        chk("hold_rr", bus1.rR_o, h_idx);
      end
      if (bus1.done_o) begin
        dones++;
        chk("done_no_valid", bus1.valid_o, 0);
        finished = 1'b1;
      end else if (bus1.valid_o) begin
        chk("word_idx", bus1.idx_o, exp_idx);
        chk("word_val", bus1.dout_o, rf[exp_idx]);
        chk("word_busy", bus1.busy_o, 1);
        if (bus1.idx_o == abort_idx) begin
          bus1.abort_i = 1'b1;
          step();
          bus1.abort_i = 1'b0;
          chk("abort_valid", bus1.valid_o, 0);
          chk("abort_busy", bus1.busy_o, 0);
          chk("abort_done", bus1.done_o, 0);
          for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_no_done", bus1.done_o, 0);
          end
          words = exp_idx;
          return;
        end
        if (bus1.idx_o == restart_idx && !restarted) begin
          bus1.start_i = 1'b1;
          restarted = 1'b1;
        end
        if (bus1.idx_o == stall_idx && stall > 0) begin
          bus1.ready_i = 1'b0;
          stall--;
        end else begin
          bus1.ready_i = ($urandom_range(99) < ready_pct);
        end
        prev_hold = !bus1.ready_i;
        h_idx = bus1.idx_o;
        h_dout = bus1.dout_o;
        if (bus1.ready_i) exp_idx++;
      end else begin
        prev_hold = 1'b0;
        bus1.ready_i = 1'($urandom_range(1));
      end
      step();
    end
    chk("dump_finished", finished, 1);
    chk("dump_words", exp_idx, 32);
    bus1.ready_i = 1'b1;
    step();
    chk("post_done_pulse", bus1.done_o, 0);
    chk("post_busy", bus1.busy_o, 0);
    chk("post_rr", bus1.rR_o, 0);
    chk("done_count", dones, 1);
    words = exp_idx;
  endtask

  initial begin
    int w;
    int busy_cnt;
    int word_cnt;
    int done_cnt;
    int exp_rr;

    bus1.start_i = 1'b0; bus1.abort_i = 1'b0; bus1.ready_i = 1'b0;
    bus2.start_i = 1'b0; bus2.abort_i = 1'b0; bus2.ready_i = 1'b0;
    fill_pattern();

    // Reset values.
    repeat (2) step();
    chk("rst_valid", bus1.valid_o, 0);
    chk("rst_busy", bus1.busy_o, 0);
    chk("rst_done", bus1.done_o, 0);
    chk("rst_rr", bus1.rR_o, 0);
    chk("rst_dout", bus1.dout_o, 0);
    chk("rst_idx", bus1.idx_o, 0);
    chk("rst_busy_one", bus2.busy_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Full dump, ready tied high: cycle-exact timing from the start edge.
    bus1.ready_i = 1'b1;
    bus1.start_i = 1'b1;
    step();
    bus1.start_i = 1'b0;
    for (int t = 0; t <= 66; t++) begin
      exp_rr = (t <= 64) ? ((t / 2 > 31) ? 31 : t / 2) : 0;
      chk("a_valid", bus1.valid_o, ((t % 2 == 1) && (t <= 63)) ? 1 : 0);
      chk("a_busy", bus1.busy_o, (t <= 64) ? 1 : 0);
      chk("a_done", bus1.done_o, (t == 64) ? 1 : 0);
      chk("a_rr", bus1.rR_o, exp_rr);
      if ((t % 2 == 1) && (t <= 63)) begin
        chk("a_idx", bus1.idx_o, (t - 1) / 2);
        chk("a_dout", bus1.dout_o, ((t - 1) / 2) * 32'h1111_1111);
      end
      if (t == 11) chk("a_x5", bus1.dout_o, 32'h5555_5555);
      if (t == 1) chk("a_x0", bus1.dout_o, 32'h0);
      step();
    end

    // Stall five cycles on idx 3.
    dump(100, 3, 5, -1, -1, w);

    // Randomised register contents and randomised ready.
    fill_random();
    dump(60, -1, 0, -1, -1, w);
    fill_random();
    dump(35, 20, 3, -1, -1, w);

    // Start re-pulsed mid-dump at idx 7 is ignored.
    dump(100, -1, 0, 7, -1, w);

    // Abort while word 12 is pending, then abort+start in IDLE, then restart.
    fill_random();
    dump(100, -1, 0, -1, 12, w);
    chk("abort_words", w, 12);
    bus1.start_i = 1'b1;
    bus1.abort_i = 1'b1;
    step();
    bus1.start_i = 1'b0;
    bus1.abort_i = 1'b0;
    chk("abort_start_idle", bus1.busy_o, 0);
    step();
    chk("abort_start_idle2", bus1.busy_o, 0);
    dump(80, -1, 0, -1, -1, w);

    // Single-register window on the 10..10 instance.
    bus2.ready_i = 1'b1;
    bus2.start_i = 1'b1;
    busy_cnt = 0; word_cnt = 0; done_cnt = 0;
    step();
    bus2.start_i = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (bus2.busy_o) busy_cnt++;
      if (bus2.done_o) done_cnt++;
      if (bus2.valid_o) begin
        word_cnt++;
        chk("one_idx", bus2.idx_o, 10);
        chk("one_val", bus2.dout_o, rf[10]);
      end
      step();
    end
    chk("one_busy_cycles", busy_cnt, 3);
    chk("one_words", word_cnt, 1);
    chk("one_dones", done_cnt, 1);

    // Asynchronous reset while in READ for idx 2.
    fill_pattern();
    bus1.ready_i = 1'b1;
    bus1.start_i = 1'b1;
    step();
    bus1.start_i = 1'b0;
    repeat (4) step();
    chk("pre_rst_dout", bus1.dout_o, 32'h1111_1111);
    chk("pre_rst_rr", bus1.rR_o, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", bus1.valid_o, 0);
    chk("arst_busy", bus1.busy_o, 0);
    chk("arst_done", bus1.done_o, 0);
    chk("arst_rr", bus1.rR_o, 0);
    chk("arst_dout", bus1.dout_o, 0);
    chk("arst_idx", bus1.idx_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("rel_busy", bus1.busy_o, 0);
    chk("rel_rr", bus1.rR_o, 0);
    chk("rel_valid", bus1.valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
